// File: rtl/shared_port_arbiter_pkg.sv
// Sizing constants, types and helpers shared by the shared_port_arbiter slice.
package shared_port_arbiter_pkg;

  localparam int N_REQ    = 4;
  localparam int MAX_HOLD = 4;
  localparam int DATA_W   = 8;
  localparam int IDX_W    = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1;
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  function automatic logic [N_REQ-1:0] onehot(input idx_t i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/shared_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module rr_picker
  import shared_port_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output idx_t             idx,
  output logic             found
);

  int cand;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + 1 + i) % N_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = idx_t'(cand);
      end
    end
  end

endmodule

// File: rtl/shared_port_arbiter.sv
// Round-robin arbiter sharing one registered resource port among N_REQ requesters.
// Optional grant counter output enabled by SHARED_PORT_ARBITER_GRANT_COUNT_EN.
module shared_port_arbiter
  import shared_port_arbiter_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          gnt_o,
  output idx_t                      gnt_idx_o,
  output logic                      busy_o,
  output logic                      res_valid_o,
  output logic [DATA_W-1:0]         res_data_o
`ifdef SHARED_PORT_ARBITER_GRANT_COUNT_EN
  ,
  output logic [15:0]               grant_count_o
`endif
);

  arb_state_e          state, state_nxt;
  idx_t                rr_ptr, rr_ptr_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [N_REQ-1:0]    gnt_nxt;
  idx_t                gnt_idx_nxt;
  logic                valid_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                new_grant;
  logic                cur_req;
  logic                rel;
  idx_t                pick_ptr;
  idx_t                pick_idx;
  logic                pick_found;

  // While granted, the picker searches from the current grant so a release hands off immediately.
  assign pick_ptr = (state == GRANT) ? gnt_idx_o : rr_ptr;
  assign busy_o   = (state == GRANT);
  assign cur_req  = req_i[gnt_idx_o];
  assign rel      = (state == GRANT) &&
                    (!cur_req || (hold_cnt == HOLD_W'(MAX_HOLD - 1)));

  rr_picker u_picker (
    .req   (req_i),
    .ptr   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt_o;
    gnt_idx_nxt = gnt_idx_o;
    valid_nxt   = 1'b0;
    data_nxt    = res_data_o;
    new_grant   = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt   = GRANT;
          gnt_nxt     = onehot(pick_idx);
          gnt_idx_nxt = pick_idx;
          hold_nxt    = '0;
          new_grant   = 1'b1;
        end
      end
      GRANT: begin
        if (cur_req) begin
          valid_nxt = 1'b1;
          data_nxt  = req_data_i[int'(gnt_idx_o)*DATA_W +: DATA_W];
          hold_nxt  = hold_cnt + HOLD_W'(1);
        end
        if (rel) begin
          rr_ptr_nxt = gnt_idx_o;
          if (pick_found) begin
            gnt_nxt     = onehot(pick_idx);
            gnt_idx_nxt = pick_idx;
            hold_nxt    = '0;
            new_grant   = 1'b1;
          end else begin
            state_nxt   = IDLE;
            gnt_nxt     = '0;
            gnt_idx_nxt = '0;
            hold_nxt    = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= idx_t'(N_REQ - 1);
      hold_cnt    <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      res_valid_o <= 1'b0;
      res_data_o  <= '0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      hold_cnt    <= hold_nxt;
      gnt_o       <= gnt_nxt;
      gnt_idx_o   <= gnt_idx_nxt;
      res_valid_o <= valid_nxt;
      res_data_o  <= data_nxt;
    end
  end

`ifdef SHARED_PORT_ARBITER_GRANT_COUNT_EN
  // Counts every issued grant, re-grants included; wraps naturally at 16 bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count_o <= '0;
    end else if (new_grant) begin
      grant_count_o <= grant_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Self-checking bench for shared_port_arbiter: directed scenarios plus random traffic vs. a behavioural model.
module tb_shared_port_arbiter;
  import shared_port_arbiter_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic [N_REQ-1:0]        req_i = '0;
  logic [N_REQ*DATA_W-1:0] req_data_i = '0;
  logic [N_REQ-1:0]        gnt_o;
  idx_t                    gnt_idx_o;
  logic                    busy_o;
  logic                    res_valid_o;
  logic [DATA_W-1:0]       res_data_o;
`ifdef SHARED_PORT_ARBITER_GRANT_COUNT_EN
  logic [15:0]             grant_count_o;
`endif

  int checks = 0;
  int fails  = 0;

  // Behavioural model state: who holds the port, beats taken, last releaser.
  bit               m_busy;
  int               m_g;
  int               m_beats;
  int               m_ptr;
  logic             m_valid;
  logic [DATA_W-1:0] m_data;
  int               m_count;

  shared_port_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .req_i       (req_i),
    .req_data_i  (req_data_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .busy_o      (busy_o),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o)
`ifdef SHARED_PORT_ARBITER_GRANT_COUNT_EN
    ,
    .grant_count_o (grant_count_o)
`endif
  );

  always #5 clock = ~clock;

  function automatic int pick(input logic [N_REQ-1:0] r, input int after);
    for (int i = 1; i <= N_REQ; i++) begin
      if (r[(after + i) % N_REQ]) return (after + i) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] word_of(input int k);
    return req_data_i[k*DATA_W +: DATA_W];
  endfunction

  task automatic model_step();
    int p;
    if (reset) begin
      m_busy = 0; m_g = 0; m_beats = 0; m_ptr = N_REQ - 1;
      m_valid = 1'b0; m_data = '0; m_count = 0;
    end else if (!m_busy) begin
      m_valid = 1'b0;
      p = pick(req_i, m_ptr);
      if (p >= 0) begin
        m_busy = 1; m_g = p; m_beats = 0; m_count++;
      end
    end else begin
      bit done;
      m_valid = req_i[m_g];
      if (req_i[m_g]) begin
        m_data = word_of(m_g);
        m_beats++;
      end
      done = !req_i[m_g] || (m_beats == MAX_HOLD);
      if (done) begin
        m_ptr = m_g;
        p = pick(req_i, m_g);
        if (p >= 0) begin
          m_g = p; m_beats = 0; m_count++;
        end else begin
          m_busy = 0; m_g = 0;
        end
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [N_REQ-1:0] eg;
    eg = m_busy ? (N_REQ'(1) << m_g) : '0;
    checkValue("gnt", 32'(gnt_o), 32'(eg));
    checkValue("gnt_idx", 32'(gnt_idx_o), m_busy ? 32'(m_g) : 32'd0);
    checkValue("busy", 32'(busy_o), 32'(m_busy));
    checkValue("res_valid", 32'(res_valid_o), 32'(m_valid));
    checkValue("res_data", 32'(res_data_o), 32'(m_data));
`ifdef SHARED_PORT_ARBITER_GRANT_COUNT_EN
    checkValue("grant_count", 32'(grant_count_o), 32'(m_count & 16'hFFFF));
`endif
  endtask

  task automatic applyStimulus(input logic rst, input logic [N_REQ-1:0] req);
    reset = rst;
    req_i = req;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b1, '0);
    tick(); tick();
    checkValue("reset_gnt", 32'(gnt_o), 32'd0);
    checkValue("reset_valid", 32'(res_valid_o), 32'd0);

    // Single requester 2 holds, then is re-granted after MAX_HOLD beats
    req_data_i[2*DATA_W +: DATA_W] = 8'hA5;
    applyStimulus(1'b0, 4'b0100);
    tick();
    checkValue("first_grant_latency", 32'(gnt_o), 32'(4'b0100));
    for (int i = 0; i < 4; i++) begin
      tick();
      checkValue("beat_valid", 32'(res_valid_o), 32'd1);
      checkValue("beat_data", 32'(res_data_o), 32'hA5);
    end
    checkValue("regrant_2", 32'(gnt_o), 32'(4'b0100));
    tick();

    // All requesting from reset: rotation 0,1,2,3,0 with no bubble
    applyStimulus(1'b1, 4'b1111);
    tick();
    applyStimulus(1'b0, 4'b1111);
    for (int i = 0; i < 17; i++) begin
      tick();
      checkValue("rotation", 32'(gnt_idx_o), 32'((i / 4) % 4));
      checkValue("rotation_busy", 32'(busy_o), 32'd1);
    end

    // Requester 1 drops after 2 beats while 3 waits
    applyStimulus(1'b1, '0);
    tick();
    applyStimulus(1'b0, 4'b1010);
    tick();
    checkValue("drop_grant1", 32'(gnt_o), 32'(4'b0010));
    tick(); tick();
    applyStimulus(1'b0, 4'b1000);
    tick();
    checkValue("drop_handoff", 32'(gnt_o), 32'(4'b1000));
    checkValue("drop_no_beat", 32'(res_valid_o), 32'd0);
    checkValue("drop_busy", 32'(busy_o), 32'd1);

    // Simultaneous 1010 once rr_ptr = 1
    applyStimulus(1'b1, '0);
    tick();
    applyStimulus(1'b0, 4'b0010);
    tick();
    applyStimulus(1'b0, 4'b0000);
    tick();
    applyStimulus(1'b0, 4'b1010);
    tick();
    checkValue("simul_first", 32'(gnt_o), 32'(4'b1000));
    for (int i = 0; i < 4; i++) tick();
    checkValue("simul_second", 32'(gnt_o), 32'(4'b0010));

    // Reset in the middle of a grant drops the beat
    applyStimulus(1'b1, 4'b1010);
    tick();
    checkValue("rst_gnt", 32'(gnt_o), 32'd0);
    checkValue("rst_valid", 32'(res_valid_o), 32'd0);
    checkValue("rst_busy", 32'(busy_o), 32'd0);
    applyStimulus(1'b0, 4'b0001);
    tick();
    checkValue("post_rst_grant0", 32'(gnt_o), 32'(4'b0001));

`ifdef SHARED_PORT_ARBITER_GRANT_COUNT_EN
    applyStimulus(1'b1, 4'b1111);
    tick();
    applyStimulus(1'b0, 4'b1111);
    for (int i = 0; i < 40; i++) tick();
    checkValue("grant_count_40", 32'(grant_count_o), 32'd10);
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!(m_busy && m_g == k && req_i[k])) req_data_i[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      applyStimulus(($urandom_range(0, 49) == 0), N_REQ'($urandom));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
